iiitb_cg_ctrl: RTL
==================

IIITB_CG_CTRL -- requirements
Module: iiitb_cg_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: idle cycles en_out stays high after the last activity; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of gated_cnt.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 d0  input  1  raw data bit 0 destined for the gated register bank.
REQ-006 d1  input  1  raw data bit 1 destined for the gated register bank.
REQ-007 force_on  input  1  forces the clock enable on while high.
REQ-008 en_out  output  1  clock-gate request; drives the downstream gating cell's enable input ("in").
REQ-009 d0_o  output  1  registered d0; drives the gated bank's d0.
REQ-010 d1_o  output  1  registered d1; drives the gated bank's d1.
REQ-011 state  output  2  FSM state: IDLE=00, ACTIVE=01, HOLD=10; 11 is unreachable.
REQ-012 gated_cnt  output  CNT_W  count of cycles spent in IDLE (clock gated off).

Function
REQ-013 d0_o and d1_o SHALL capture d0 and d1 on every rising clk edge, regardless of FSM state.
REQ-014 change SHALL be combinational: (d0 != d0_o) | (d1 != d1_o).
REQ-015 wake SHALL be combinational: change | force_on.
REQ-016 IDLE transitions:
- wake=1 -> ACTIVE.
- Otherwise -> stay in IDLE.
REQ-017 ACTIVE transitions:
- wake=1 -> stay in ACTIVE.
- Otherwise -> HOLD, loading hold_cnt with HOLD_CYCLES-1.
REQ-018 HOLD transitions:
- wake=1 -> ACTIVE.
- Else hold_cnt==0 -> IDLE.
- Else stay in HOLD and decrement hold_cnt by 1.
REQ-019 en_out SHALL be a Moore output, equal to 1 in ACTIVE and HOLD and 0 in IDLE.
- No combinational path from any input to en_out.
REQ-020 en_out and d0_o/d1_o SHALL update on the same edge, so the data change and the enable request reach the gating stage together.
REQ-021 After a single isolated change with force_on=0, en_out SHALL stay high for exactly HOLD_CYCLES+1 cycles.
REQ-022 A wake during HOLD SHALL return the FSM to ACTIVE on that edge and discard the remaining hold_cnt; the next idle period reloads it.
REQ-023 gated_cnt SHALL increment by 1 on each edge where state==IDLE and the FSM stays in IDLE.
- It SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 gated_cnt SHALL hold its value in ACTIVE and HOLD.
REQ-025 If change and force_on are both high, the behaviour SHALL be identical to either one alone.
REQ-026 hold_cnt SHALL be 8 bits wide; with HOLD_CYCLES=1 the FSM goes HOLD(0) -> IDLE with no decrement.

Reset
REQ-027 On a rising edge with rst=1, the block SHALL reset to:
- state=IDLE, en_out=0, hold_cnt=0.
- d0_o=0, d1_o=0, gated_cnt=0.
REQ-028 rst SHALL take priority over all other inputs, including mid-ACTIVE or mid-HOLD; the FSM restarts in IDLE on the next edge.
REQ-029 The first edge after rst deasserts SHALL compare the inputs against d0_o=d1_o=0.
- A non-zero input on that edge counts as a change.

Verification
REQ-030 Reset, then hold d0=d1=0 for 10 edges -> state=00, en_out=0, gated_cnt=10.
REQ-031 HOLD_CYCLES=4: d0 0->1 before edge k, then stable:
- en_out=1 after edges k..k+4, state 01, 10, 10, 10, 10.
- en_out=0 and state=00 after edge k+5; d0_o=1 after edge k.
REQ-032 d1 toggles while the FSM is in HOLD with hold_cnt=1 -> state=01 after that edge; en_out then stays high for a further 5 cycles after the last toggle.
REQ-033 force_on=1 for 20 edges with data stable -> en_out=1 throughout and gated_cnt unchanged; after force_on drops, en_out falls 5 cycles later.
REQ-034 CNT_W=4, idle for 20 edges -> gated_cnt saturates at 15 and holds at 15.
REQ-035 Assert rst for one edge while in HOLD with hold_cnt=2 -> all outputs 0 and state=00 after that edge; the next d0 change re-enters ACTIVE normally.

Source files
------------

// File: rtl/iiitb_cg_ctrl.sv
// Clock-gate request controller.
// A registered copy of d0/d1 is kept for the gated register bank. Any difference
// between the raw inputs and that copy, or force_on, wakes the controller. The
// controller holds en_out high while there is activity, then for HOLD_CYCLES
// further idle cycles, and then drops it. gated_cnt counts the cycles spent
// fully idle and saturates at its maximum value.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | no recent activity; en_out low; idle cycles are counted
//   ACTIVE | a change or force_on was seen on the last edge; en_out high
//   HOLD   | counting down the idle tail in hold_cnt; en_out still high
module iiitb_cg_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d0,
  input  logic             d1,
  input  logic             force_on,
  output logic             en_out,
  output logic             d0_o,
  output logic             d1_o,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] gated_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  // Reload value for the idle tail. The HOLD state itself spends one cycle
  // with hold_cnt==0, so HOLD_CYCLES-1 gives HOLD_CYCLES cycles in HOLD.
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       hold_q;
  logic [7:0]       hold_d;
  logic [CNT_W-1:0] cnt_d;
  logic             en_d;
  logic             change;
  logic             wake;

  // Activity detection against the data currently presented to the gated bank.
  always_comb begin
    change = (d0 != d0_o) | (d1 != d1_o);
    wake   = change | force_on;
  end

  // Next-state, hold countdown, enable request and idle-counter update.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = gated_cnt;
    en_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (wake) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!wake) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        // A wake here abandons the remaining countdown; the next entry into
        // HOLD reloads it from scratch.
        if (wake) begin
          state_d = ACTIVE;
        end else if (hold_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // en_out is registered from the next state so it rises on the same edge
    // as the data capture, with no input-to-output combinational path.
    en_d = (state_d != IDLE);

    if ((state_q == IDLE) && (state_d == IDLE) && (gated_cnt != CNT_MAX)) begin
      cnt_d = gated_cnt + 1'b1;
    end
  end

  // State, countdown, enable, data capture and idle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= 8'd0;
      en_out    <= 1'b0;
      d0_o      <= 1'b0;
      d1_o      <= 1'b0;
      gated_cnt <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      en_out    <= en_d;
      d0_o      <= d0;
      d1_o      <= d1;
      gated_cnt <= cnt_d;
    end
  end

  assign state = state_q;

endmodule
